// File: rtl/approx_mul_pipe.sv
// Purpose : pipelined WIDTHxWIDTH multiplier; partial-product rows are paired and the low
//           APPROX_COLS overlap columns of each pair are compressed exactly, by OR, or dropped.
// Latency : 2 cycles from input handshake to out_valid, 1 operation per cycle sustained.
// Backpressure: out_ready low holds S2; in_ready falls once S1 and S2 both hold data.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    operand handshake carrying x, y and mode
//                        (0 exact, 1 OR-sum, 2 eliminate, 3 treated as exact)
//   out_valid/out_ready  product handshake carrying p (2*WIDTH bits)
// Optional (APPROX_MUL_ERR_STATS_EN): stat_clr in; err_sum, err_max, err_cnt out, which
//   accumulate |exact - p| over output transfers.
module approx_mul_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 3,
    parameter int ERR_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef APPROX_MUL_ERR_STATS_EN
    input  logic                 stat_clr,
    output logic [ERR_W-1:0]     err_sum,
    output logic [2*WIDTH-1:0]   err_max,
    output logic [ERR_W-1:0]     err_cnt,
`endif
    output logic [2*WIDTH-1:0]   p
);
    localparam int NP = WIDTH / 2;   // number of row pairs
    localparam int PW = 2 * WIDTH;   // product width
    localparam int VW = WIDTH + 1;   // relative columns 0..WIDTH of a pair

    logic s1_valid;
    logic s1_adv;
    logic s2_adv;
    logic accept;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !rst;
    assign accept   = in_valid && in_ready;

    // Stage 1 compression: one sum vector and one carry vector per row pair.
    // carry[c+1] holds the half-adder carry out of column c.
    logic [VW-1:0] c1_sum   [NP];
    logic [VW-1:0] c1_carry [NP];
    logic          col_a;
    logic          col_b;

    always_comb begin
        col_a = 1'b0;
        col_b = 1'b0;
        for (int k = 0; k < NP; k++) begin
            c1_sum[k]   = '0;
            c1_carry[k] = '0;
            c1_sum[k][0]     = y[0] & x[2*k];
            c1_sum[k][WIDTH] = y[WIDTH-1] & x[2*k+1];
            for (int c = 1; c < WIDTH; c++) begin
                col_a = y[c] & x[2*k];
                col_b = y[c-1] & x[2*k+1];
                if (c <= APPROX_COLS && mode == 2'd1) begin
                    c1_sum[k][c] = col_a | col_b;
                end else if (c <= APPROX_COLS && mode == 2'd2) begin
                    c1_sum[k][c] = 1'b0;
                end else begin
                    c1_sum[k][c]     = col_a ^ col_b;
                    c1_carry[k][c+1] = col_a & col_b;
                end
            end
        end
    end

    logic [VW-1:0] s1_sum   [NP];
    logic [VW-1:0] s1_carry [NP];
`ifdef APPROX_MUL_ERR_STATS_EN
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < NP; k++) begin
                s1_sum[k]   <= '0;
                s1_carry[k] <= '0;
            end
`ifdef APPROX_MUL_ERR_STATS_EN
            s1_x <= '0;
            s1_y <= '0;
`endif
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            // Data only loads on a real transfer so idle bubbles keep the last value.
            if (accept) begin
                for (int k = 0; k < NP; k++) begin
                    s1_sum[k]   <= c1_sum[k];
                    s1_carry[k] <= c1_carry[k];
                end
`ifdef APPROX_MUL_ERR_STATS_EN
                s1_x <= x;
                s1_y <= y;
`endif
            end
        end
    end

    // Stage 2: exact sum of every pair's vectors at weight 2^(2k).
    logic [PW-1:0] c2_p;

    always_comb begin
        c2_p = '0;
        for (int k = 0; k < NP; k++) begin
            c2_p = c2_p + ((PW'(s1_sum[k]) + PW'(s1_carry[k])) << (2 * k));
        end
    end

`ifdef APPROX_MUL_ERR_STATS_EN
    logic [PW-1:0] p_exact;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            p         <= '0;
`ifdef APPROX_MUL_ERR_STATS_EN
            p_exact   <= '0;
`endif
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                p <= c2_p;
`ifdef APPROX_MUL_ERR_STATS_EN
                p_exact <= PW'(s1_x) * PW'(s1_y);
`endif
            end
        end
    end

`ifdef APPROX_MUL_ERR_STATS_EN
    // Accumulator headroom wide enough for either operand plus one carry bit.
    localparam int SW = ((ERR_W > PW) ? ERR_W : PW) + 1;

    logic [PW-1:0] err_abs;
    logic [SW-1:0] sum_ext;
    logic          out_xfer;

    assign out_xfer = out_valid && out_ready;
    assign err_abs  = (p_exact >= p) ? (p_exact - p) : (p - p_exact);
    assign sum_ext  = SW'(err_sum) + SW'(err_abs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sum <= '0;
            err_max <= '0;
            err_cnt <= '0;
        end else if (stat_clr) begin
            // Clear wins over a coincident transfer.
            err_sum <= '0;
            err_max <= '0;
            err_cnt <= '0;
        end else if (out_xfer) begin
            err_sum <= (sum_ext > SW'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : sum_ext[ERR_W-1:0];
            err_cnt <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
            if (err_abs > err_max) begin
                err_max <= err_abs;
            end
        end
    end
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed bench for approx_mul_pipe at WIDTH=8, APPROX_COLS=3: mode vectors, a stalled
// stream of 10 operations, mid-flight reset, and the error statistics when enabled.
module tb_approx_mul_pipe;
    localparam int W  = 8;
    localparam int AC = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   p;
`ifdef APPROX_MUL_ERR_STATS_EN
    logic             stat_clr;
    logic [31:0]      err_sum;
    logic [2*W-1:0]   err_max;
    logic [31:0]      err_cnt;
`endif

    approx_mul_pipe #(.WIDTH(W), .APPROX_COLS(AC), .ERR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef APPROX_MUL_ERR_STATS_EN
        .stat_clr  (stat_clr),
        .err_sum   (err_sum),
        .err_max   (err_max),
        .err_cnt   (err_cnt),
`endif
        .p         (p)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: exact product minus what each approximated column loses.
    // OR keeps a^b + a&b instead of a^b + 2(a&b): loses a&b. Eliminate loses a+b.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] rx, input logic [W-1:0] ry,
                                                input logic [1:0] rm);
        int   ex;
        int   loss;
        logic a;
        logic b;
        ex   = int'(rx) * int'(ry);
        loss = 0;
        for (int k = 0; k < W / 2; k++) begin
            for (int c = 1; c <= AC; c++) begin
                a = ry[c] & rx[2*k];
                b = ry[c-1] & rx[2*k+1];
                if (rm == 2'd1) loss += int'(a & b) << (c + 2 * k);
                else if (rm == 2'd2) loss += (int'(a) + int'(b)) << (c + 2 * k);
            end
        end
        return 16'(ex - loss);
    endfunction

    // One isolated operation with out_ready high; checks the 2-cycle latency and result.
    task automatic do_op(input string tag, input logic [W-1:0] ox, input logic [W-1:0] oy,
                         input logic [1:0] om, input logic [2*W-1:0] exp);
        x = ox; y = oy; mode = om; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        tick;
        in_valid = 1'b0;
        check({tag, ".lat1_valid"}, 64'(out_valid), 64'd0);
        tick;
        check({tag, ".lat2_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".p"}, 64'(p), 64'(exp));
        tick;
    endtask

    logic [W-1:0]   sx   [10] = '{8'h12, 8'hA5, 8'h3C, 8'hFF, 8'h07, 8'h81, 8'h5A, 8'hC3, 8'h0F, 8'h66};
    logic [W-1:0]   sy   [10] = '{8'h34, 8'h5A, 8'hC3, 8'h01, 8'hEE, 8'h7F, 8'h5A, 8'h99, 8'hF0, 8'h3B};
    logic [1:0]     sm   [10] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};
    logic [2*W-1:0] sexp [10];

    initial begin
        int       issued;
        int       recv;
        bit       saw_drop;
        bit       acc;
        bit       stalled;
        logic [2*W-1:0] prev_p;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; mode = '0;
`ifdef APPROX_MUL_ERR_STATS_EN
        stat_clr = 1'b0;
`endif
        tick;
        tick;
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.p", 64'(p), 64'd0);
        check("reset.in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("release.in_ready", 64'(in_ready), 64'd1);

        do_op("exact_ff", 8'hFF, 8'hFF, 2'd0, 16'hFE01);
        do_op("or_3x3",   8'd3,  8'd3,  2'd1, 16'd7);
`ifdef APPROX_MUL_ERR_STATS_EN
        check("stats.cnt", 64'(err_cnt), 64'd2);
        check("stats.sum", 64'(err_sum), 64'd2);
        check("stats.max", 64'(err_max), 64'd2);
`endif
        do_op("elim_3x3", 8'd3,  8'd3,  2'd2, 16'd1);
        do_op("rsvd_3x3", 8'd3,  8'd3,  2'd3, 16'd9);

        // Back-to-back stream with a 3-cycle output stall.
        for (int i = 0; i < 10; i++) sexp[i] = ref_mul(sx[i], sy[i], sm[i]);
        issued = 0; recv = 0; saw_drop = 1'b0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 7);
            in_valid  = (issued < 10);
            if (issued < 10) begin
                x = sx[issued]; y = sy[issued]; mode = sm[issued];
            end
            #1;
            check("stream.in_ready", 64'(in_ready), 64'((issued - recv < 2) || out_ready));
            if (!in_ready) saw_drop = 1'b1;
            acc     = in_valid && in_ready;
            stalled = out_valid && !out_ready;
            prev_p  = p;
            if (out_valid && out_ready) begin
                check("stream.p", 64'(p), 64'(sexp[recv]));
                recv++;
            end
            tick;
            if (acc) issued++;
            if (stalled) begin
                check("stream.hold_valid", 64'(out_valid), 64'd1);
                check("stream.hold_p", 64'(p), 64'(prev_p));
            end
        end
        in_valid = 1'b0;
        check("stream.count", 64'(recv), 64'd10);
        check("stream.in_ready_dropped", 64'(saw_drop), 64'd1);
        tick;

`ifdef APPROX_MUL_ERR_STATS_EN
        // Clear coinciding with a transfer: the transfer is not counted.
        x = 8'd3; y = 8'd3; mode = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        stat_clr = 1'b1;
        tick;
        stat_clr = 1'b0;
        check("stats_clr.cnt", 64'(err_cnt), 64'd0);
        check("stats_clr.sum", 64'(err_sum), 64'd0);
        check("stats_clr.max", 64'(err_max), 64'd0);
`endif

        // Fill both stages, then reset mid-cycle.
        out_ready = 1'b0;
        x = 8'd5; y = 8'd7; mode = 2'd0; in_valid = 1'b1;
        tick;
        x = 8'd9; y = 8'd9;
        tick;
        in_valid = 1'b0;
        #1;
        check("full.out_valid", 64'(out_valid), 64'd1);
        check("full.in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.p", 64'(p), 64'd0);
        check("midrst.in_ready", 64'(in_ready), 64'd0);
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("postrst.in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("postrst.no_stale", 64'(out_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/approx_mul_pipe.md
Name: approx_mul_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 half-adder-array partial-product stage.
- Pairs adjacent partial-product rows and compresses the low overlap columns in one of three runtime-selectable modes: exact HA, OR-sum, or eliminate.
- Reduces all pairs to a final 2*WIDTH product.
- Sits between operand source and accumulator datapath behind valid/ready handshakes.

Parameters:
- WIDTH, 8: operand width; even, 4..16.
- APPROX_COLS, 3: number of low overlap columns per row pair that are approximated; 0..WIDTH-1.
- ERR_W, 32: width of error-statistics counters (optional feature only).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- mode  in  2  0 = exact, 1 = OR-sum, 2 = eliminate, 3 = reserved (treated as exact).
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- p  out  2*WIDTH  approximate product.

Behaviour:
- Row pairing:
  - Pair k (k = 0..WIDTH/2-1): top row = x[2k]&y at weight 2^(2k); bottom row = x[2k+1]&y at weight 2^(2k+1).
  - Relative column c of pair k: a = y[c]&x[2k], b = y[c-1]&x[2k+1].
  - Column 0 carries a only; column WIDTH carries b only. Both pass unchanged in all modes.
- Overlap columns c = 1..WIDTH-1:
  - If c <= APPROX_COLS and mode = 1: sum = a|b, no carry.
  - If c <= APPROX_COLS and mode = 2: sum = 0, carry = 0.
  - Otherwise (including mode 0 and 3): half adder, sum = a^b, carry = a&b at column c+1.
- Stage 1 (register S1): per pair, a sum vector (WIDTH+1 bits) and a carry vector; mode is captured at acceptance.
- Stage 2 (register S2): exact addition of all pair vectors at their weights into p, truncated to 2*WIDTH bits (cannot overflow in practice).
- Latency: exactly 2 cycles from input handshake to out_valid with no stall. Throughput: 1 operation per cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same rising edge.
  - S2 advances when !out_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advance condition, combinational; in_ready is 0 while rst is high.
  - out_valid, once asserted, holds with p stable until out_ready.
  - No loss and no duplication; order is preserved.
- Full pipeline (both stages valid, out_ready = 0): in_ready = 0.
- Simultaneous out_ready and in_valid on a full pipeline: both transfers occur in the same cycle.
- Reset:
  - Asynchronous. out_valid, s1_valid, p and all internal registers clear to 0 immediately, including mid-operation; in-flight data is discarded.
  - After reset deassertion, in_ready = 1 on the first cycle.
- When S1/S2 are not advancing, their data registers hold their values (no X propagation).

Optional Feature:
- Macro: APPROX_MUL_ERR_STATS_EN.
- Defined:
  - The exact product is computed alongside in S2.
  - Adds outputs err_sum [ERR_W], err_max [2*WIDTH] and err_cnt [ERR_W], plus input stat_clr [1].
  - On each output transfer: err_sum += |exact - p|, err_cnt += 1, err_max = max(err_max, |exact - p|). err_sum and err_cnt saturate at all-ones.
  - stat_clr clears all three on the next edge; a transfer in the same cycle is ignored by the statistics.
  - All three reset to 0.
- Undefined: these ports and this logic are absent; datapath behaviour is unchanged.

Test Plan:
- WIDTH = 8, APPROX_COLS = 3, mode 0, x = 0xFF, y = 0xFF, out_ready = 1 -> p = 0xFE01, out_valid exactly 2 cycles after acceptance.
- mode 1, x = 3, y = 3 -> p = 7. mode 2, x = 3, y = 3 -> p = 1. mode 3, x = 3, y = 3 -> p = 9.
- Back-to-back stream of 10 random operations with out_ready low for 3 cycles mid-stream:
  - in_ready drops once 2 operations are held.
  - All 10 results emerge in order, matching the reference model.
  - p stays stable while stalled.
- Assert rst for 1 cycle while S1 and S2 are valid -> out_valid = 0 and p = 0 immediately; in_ready = 1 after release; no stale output appears.
- With APPROX_MUL_ERR_STATS_EN: exact 0xFF×0xFF, then mode 1 3×3 -> err_cnt = 2, err_sum = 2, err_max = 2.
- With APPROX_MUL_ERR_STATS_EN: stat_clr asserted in the same cycle as a transfer -> all stats = 0 on the next cycle.
